// File: rtl/ftl_bram_reader_pkg.sv
// Shared types and constants for the FTL BRAM read engine (package ftl_pkg).
// Used by ftl_skid_fifo, ftl_bram_reader_if and ftl_bram_reader.
package ftl_pkg;

    localparam int FTL_DATA       = 32;
    localparam int FTL_ADDR       = 7;
    localparam int FTL_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } ftl_state_e;

endpackage

// File: rtl/ftl_bram_reader_if.sv
// Bus bundle for ftl_bram_reader: the read-only BRAM port and the outgoing
// valid/ready word stream. master = reader side, slave = BRAM/sink side.
interface ftl_bram_reader_if #(
    parameter int DATA = ftl_pkg::FTL_DATA,
    parameter int ADDR = ftl_pkg::FTL_ADDR
);

    logic            bram_wr;
    logic [ADDR-1:0] bram_addr;
    logic [DATA-1:0] bram_din;
    logic [DATA-1:0] bram_dout;

    logic [DATA-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;

    modport master (
        output bram_wr, bram_addr, bram_din,
        input  bram_dout,
        output m_data, m_valid, m_last,
        input  m_ready
    );

    modport slave (
        input  bram_wr, bram_addr, bram_din,
        output bram_dout,
        input  m_data, m_valid, m_last,
        output m_ready
    );

endinterface

// File: rtl/ftl_skid_fifo.sv
// Two-entry registered FIFO holding {last, data} words between the BRAM read
// pipeline and the stream output. Depth is fixed at two, so 1-bit pointers.
module ftl_skid_fifo
    import ftl_pkg::*;
#(
    parameter int WIDTH = FTL_DATA + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [FTL_SKID_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic                                 wr_ptr_q, wr_ptr_d;
    logic                                 rd_ptr_q, rd_ptr_d;
    logic [1:0]                           count_q, count_d;

    // Next storage, pointers and occupancy; push+pop together keeps the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Register the FIFO state; reset clears storage so the output word reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/ftl_bram_reader.sv
// Streams len words from the FTL sector BRAM starting at base_addr, turning the
// RAM's one-cycle registered read into a valid/ready stream with a last flag.
// Optional abort input is enabled by defining FTL_BRAM_READER_ABORT_EN.
module ftl_bram_reader
    import ftl_pkg::*;
#(
    parameter int DATA = FTL_DATA,
    parameter int ADDR = FTL_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR-1:0]    base_addr,
    input  logic [ADDR:0]      len,
`ifdef FTL_BRAM_READER_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    ftl_bram_reader_if.master  bus
);

    localparam logic [ADDR-1:0] ADDR_ONE = {{(ADDR-1){1'b0}}, 1'b1};
    localparam logic [ADDR:0]   LEN_ONE  = {{ADDR{1'b0}}, 1'b1};

    ftl_state_e      state_q, state_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [ADDR:0]   len_q, len_d;
    logic [ADDR:0]   issued_q, issued_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [1:0]      fifo_count;
    logic [DATA:0]   fifo_rdata;
    logic [2:0]      slots_used;
    logic            can_issue;
    logic            final_issue;
    logic            abort_req;

`ifdef FTL_BRAM_READER_ABORT_EN
    assign abort_req = abort & busy_q;
`else
    assign abort_req = 1'b0;
`endif

    // A slot freed by this cycle's pop is reusable now, which keeps 1 word/cycle.
    assign fifo_pop    = !fifo_empty && bus.m_ready;
    assign slots_used  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    assign can_issue   = !fifo_full && (slots_used < 3'(FTL_SKID_DEPTH));
    assign final_issue = (issued_q == len_q - LEN_ONE);

    // FSM, address counter and issue bookkeeping; abort overrides everything.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        issued_d        = issued_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        busy_d          = busy_q;
        done_d          = 1'b0;
        fifo_flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        busy_d   = 1'b1;
                        addr_d   = base_addr;
                        len_d    = len;
                        issued_d = '0;
                    end
                end
            end
            READ: begin
                if (can_issue) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = final_issue;
                    addr_d          = addr_q + ADDR_ONE;
                    issued_d        = issued_q + LEN_ONE;
                    if (final_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && fifo_pop))) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (abort_req) begin
            state_d         = IDLE;
            busy_d          = 1'b0;
            done_d          = 1'b1;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
            fifo_flush      = 1'b1;
        end
    end

    // Register controller state; reset drops any transfer without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    ftl_skid_fifo #(.WIDTH(DATA + 1)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata ({inflight_last_q, bus.bram_dout}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.bram_wr   = 1'b0;
    assign bus.bram_din  = '0;
    assign bus.bram_addr = addr_q;
    assign bus.m_data    = fifo_rdata[DATA-1:0];
    assign bus.m_valid   = !fifo_empty;
    assign bus.m_last    = fifo_rdata[DATA] & !fifo_empty;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ftl_bram_reader.sv
// Bench for ftl_bram_reader: BRAM model preloaded with 0xA000_0000+i, random
// backpressure, expected words derived from (base+i) mod depth.
module tb_ftl_bram_reader;
    import ftl_pkg::*;

    localparam int DATA  = FTL_DATA;
    localparam int ADDR  = FTL_ADDR;
    localparam int DEPTH = 1 << ADDR;
    localparam int MAXC  = 600;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [ADDR-1:0] base_addr;
    logic [ADDR:0]   len;
    logic            busy;
    logic            done;
`ifdef FTL_BRAM_READER_ABORT_EN
    logic            abort;
`endif

    int total = 0;
    int bad   = 0;

    logic [DATA-1:0] mem [DEPTH];

    ftl_bram_reader_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

    ftl_bram_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef FTL_BRAM_READER_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // BRAM port model: registered read, one cycle latency
    always @(posedge clk) bus.bram_dout <= mem[bus.bram_addr];

    // Per-cycle record of one transfer, cycle k = k-th cycle after the start edge
    logic            rv [MAXC];
    logic            rr [MAXC];
    logic            rl [MAXC];
    logic            rdn[MAXC];
    logic            rb [MAXC];
    logic [DATA-1:0] rd [MAXC];
    logic [ADDR-1:0] ra [MAXC];
    int              ncyc, done_k, done_cnt, last_hs_k;
    bit              timed_out;
    logic [DATA-1:0] got_d[$];
    logic            got_l[$];

    function automatic logic [DATA-1:0] exp_word(input logic [ADDR-1:0] b, input int i);
        return 32'hA000_0000 + 32'((int'(b) + i) % DEPTH);
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k >= 6 && k < 16) ? 1'b0 : 1'($urandom_range(0, 1));
            2:       return (k < 8);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_transfer(input logic [ADDR-1:0] b, input logic [ADDR:0] l,
                                input int mode, input bit inject, input int abort_at);
        got_d.delete();
        got_l.delete();
        ncyc = 0; done_k = -1; done_cnt = 0; last_hs_k = -1; timed_out = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < MAXC; k++) begin
            bus.m_ready = ready_for(mode, k);
            if (inject && k == 5) begin
                start = 1'b1; base_addr = ~b; len = 8'd3;
            end
`ifdef FTL_BRAM_READER_ABORT_EN
            abort = (k == abort_at);
`endif
            @(negedge clk);
            rv[k] = bus.m_valid; rr[k] = bus.m_ready; rl[k] = bus.m_last;
            rd[k] = bus.m_data;  ra[k] = bus.bram_addr; rb[k] = busy; rdn[k] = done;
            ncyc = k;
            if (bus.m_valid && bus.m_ready) begin
                got_d.push_back(bus.m_data);
                got_l.push_back(bus.m_last);
                last_hs_k = k;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 2) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        bus.m_ready = 1'b0;
        start = 1'b0;
`ifdef FTL_BRAM_READER_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) #3;
            else begin
                @(negedge clk); @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
            end
            total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy%0d: got %b want 0", phase, busy); end
            total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done%0d: got %b want 0", phase, done); end
            total++; if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_last%0d: got %b%b want 00", phase, bus.m_valid, bus.m_last); end
            total++; if (bus.m_data !== '0) begin bad++; $display("[TB] FAIL reset_data%0d: got %h want 0", phase, bus.m_data); end
            total++; if (bus.bram_addr !== '0) begin bad++; $display("[TB] FAIL reset_addr%0d: got %h want 0", phase, bus.bram_addr); end
            total++; if (bus.bram_wr !== 1'b0 || bus.bram_din !== '0) begin bad++; $display("[TB] FAIL reset_wr_din%0d: got %b/%h want 0/0", phase, bus.bram_wr, bus.bram_din); end
        end
    endtask

    task automatic test_basic_stream();
        int first_v;
        logic [ADDR-1:0] b = 7'h10;
        int l = 8;
        run_transfer(b, 8'(l), 0, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL basic_timeout: got %b want 0", timed_out); end
        total++; if (got_d.size() !== l) begin bad++; $display("[TB] FAIL basic_count: got %0d want %0d", got_d.size(), l); end
        for (int i = 0; i < got_d.size() && i < l; i++) begin
            total++;
            if (got_d[i] !== exp_word(b, i) || got_l[i] !== (i == l - 1)) begin
                bad++; $display("[TB] FAIL basic_word%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_word(b, i), (i == l - 1));
            end
        end
        first_v = -1;
        for (int k = 1; k <= ncyc; k++) if (rv[k] && first_v < 0) first_v = k;
        total++; if (first_v !== 3) begin bad++; $display("[TB] FAIL basic_first_valid: got %0d want 3", first_v); end
        for (int k = 3; k < 3 + l; k++) begin
            total++; if (rv[k] !== 1'b1) begin bad++; $display("[TB] FAIL basic_gapless%0d: got %b want 1", k, rv[k]); end
        end
        total++; if (rb[1] !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_rise: got %b want 1", rb[1]); end
        total++; if (done_k !== 3 + l || done_k !== last_hs_k + 1) begin bad++; $display("[TB] FAIL basic_done_cycle: got %0d want %0d", done_k, 3 + l); end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        total++; if (done_k > 0 && rb[done_k] !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_at_done: got %b want 0", rb[done_k]); end
    endtask

    task automatic test_wrap();
        logic [ADDR-1:0] b = 7'h7E;
        logic [ADDR-1:0] want_a;
        run_transfer(b, 8'd4, 0, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL wrap_timeout: got %b want 0", timed_out); end
        for (int k = 1; k <= 4; k++) begin
            want_a = 7'((int'(b) + k - 1) % DEPTH);
            total++; if (ra[k] !== want_a) begin bad++; $display("[TB] FAIL wrap_addr%0d: got %h want %h", k, ra[k], want_a); end
        end
        total++; if (got_d.size() !== 4) begin bad++; $display("[TB] FAIL wrap_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            total++; if (got_d[i] !== exp_word(b, i)) begin bad++; $display("[TB] FAIL wrap_word%0d: got %h want %h", i, got_d[i], exp_word(b, i)); end
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR-1:0] b = 7'($urandom_range(0, DEPTH - 1));
        int l = 16;
        int popped = 0;
        int occ;
        run_transfer(b, 8'(l), 1, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL bp_timeout: got %b want 0", timed_out); end
        total++; if (got_d.size() !== l) begin bad++; $display("[TB] FAIL bp_count: got %0d want %0d", got_d.size(), l); end
        for (int i = 0; i < got_d.size() && i < l; i++) begin
            total++;
            if (got_d[i] !== exp_word(b, i) || got_l[i] !== (i == l - 1)) begin
                bad++; $display("[TB] FAIL bp_word%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_word(b, i), (i == l - 1));
            end
        end
        for (int k = 1; k < ncyc; k++) begin
            if (rv[k] && !rr[k]) begin
                total++;
                if (rv[k+1] !== 1'b1 || rd[k+1] !== rd[k] || rl[k+1] !== rl[k]) begin
                    bad++; $display("[TB] FAIL bp_stable%0d: got %b/%h want 1/%h", k, rv[k+1], rd[k+1], rd[k]);
                end
            end
        end
        // reads issued minus words taken = words held in flight or in the skid
        for (int k = 1; k <= ncyc; k++) begin
            if (rb[k]) begin
                occ = ((int'(ra[k]) - int'(b) + DEPTH) % DEPTH) - popped;
                total++; if (occ > 2 || occ < 0) begin bad++; $display("[TB] FAIL bp_occupancy%0d: got %0d want 0..2", k, occ); end
            end
            if (rv[k] && rr[k]) popped++;
        end
    endtask

    task automatic test_zero_len();
        run_transfer(7'h33, 8'd0, 0, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL zero_timeout: got %b want 0", timed_out); end
        total++; if (done_k !== 1) begin bad++; $display("[TB] FAIL zero_done_cycle: got %0d want 1", done_k); end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL zero_done_pulses: got %0d want 1", done_cnt); end
        for (int k = 1; k <= ncyc; k++) begin
            total++; if (rb[k] !== 1'b0 || rv[k] !== 1'b0) begin bad++; $display("[TB] FAIL zero_quiet%0d: got busy=%b valid=%b want 0/0", k, rb[k], rv[k]); end
        end
    endtask

    task automatic test_len_one();
        logic [ADDR-1:0] b = 7'($urandom_range(0, DEPTH - 1));
        run_transfer(b, 8'd1, 0, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL one_timeout: got %b want 0", timed_out); end
        total++; if (got_d.size() !== 1) begin bad++; $display("[TB] FAIL one_count: got %0d want 1", got_d.size()); end
        if (got_d.size() > 0) begin
            total++; if (got_d[0] !== exp_word(b, 0) || got_l[0] !== 1'b1) begin bad++; $display("[TB] FAIL one_word: got %h/%b want %h/1", got_d[0], got_l[0], exp_word(b, 0)); end
        end
        total++; if (done_k !== last_hs_k + 1) begin bad++; $display("[TB] FAIL one_done_cycle: got %0d want %0d", done_k, last_hs_k + 1); end
    endtask

    task automatic test_start_while_busy();
        logic [ADDR-1:0] b = 7'($urandom_range(0, DEPTH - 1));
        int l = 8;
        run_transfer(b, 8'(l), 0, 1'b1, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_timeout: got %b want 0", timed_out); end
        total++; if (got_d.size() !== l) begin bad++; $display("[TB] FAIL busy_start_count: got %0d want %0d", got_d.size(), l); end
        for (int i = 0; i < got_d.size() && i < l; i++) begin
            total++;
            if (got_d[i] !== exp_word(b, i) || got_l[i] !== (i == l - 1)) begin
                bad++; $display("[TB] FAIL busy_start_word%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_word(b, i), (i == l - 1));
            end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL busy_start_done_pulses: got %0d want 1", done_cnt); end
        for (int k = done_k + 1; k <= ncyc && done_k > 0; k++) begin
            total++; if (rb[k] !== 1'b0 || rv[k] !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_after%0d: got busy=%b valid=%b want 0/0", k, rb[k], rv[k]); end
        end
    endtask

    task automatic test_full_buffer();
        logic [ADDR-1:0] b = 7'($urandom_range(0, DEPTH - 1));
        int l = DEPTH;
        int errs = 0;
        run_transfer(b, 8'(l), 1, 1'b0, -1);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL full_timeout: got %b want 0", timed_out); end
        total++; if (got_d.size() !== l) begin bad++; $display("[TB] FAIL full_count: got %0d want %0d", got_d.size(), l); end
        for (int i = 0; i < got_d.size() && i < l; i++) begin
            total++;
            if (got_d[i] !== exp_word(b, i) || got_l[i] !== (i == l - 1)) begin
                bad++; errs++;
                if (errs < 5) $display("[TB] FAIL full_word%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_word(b, i), (i == l - 1));
            end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL full_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        int dn = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 7'h20; len = 8'd8; bus.m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        total++; if (bus.m_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_active: got valid=%b busy=%b want 1/1", bus.m_valid, busy); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy_done: got %b/%b want 0/0", busy, done); end
        total++; if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== '0) begin bad++; $display("[TB] FAIL rstmid_stream: got %b/%b/%h want 0/0/0", bus.m_valid, bus.m_last, bus.m_data); end
        total++; if (bus.bram_addr !== '0) begin bad++; $display("[TB] FAIL rstmid_addr: got %h want 0", bus.bram_addr); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (bus.m_valid) hs++;
        end
        bus.m_ready = 1'b0;
        total++; if (dn !== 0 || hs !== 0) begin bad++; $display("[TB] FAIL rstmid_quiet: got done=%0d valid=%0d want 0/0", dn, hs); end
        run_transfer(7'h45, 8'd2, 0, 1'b0, -1);
        total++; if (got_d.size() !== 2 || done_cnt !== 1) begin bad++; $display("[TB] FAIL rstmid_next_count: got %0d/%0d want 2/1", got_d.size(), done_cnt); end
        for (int i = 0; i < got_d.size() && i < 2; i++) begin
            total++; if (got_d[i] !== exp_word(7'h45, i) || got_l[i] !== (i == 1)) begin bad++; $display("[TB] FAIL rstmid_next_word%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_word(7'h45, i), (i == 1)); end
        end
    endtask

`ifdef FTL_BRAM_READER_ABORT_EN
    task automatic test_abort();
        logic [ADDR-1:0] b = 7'($urandom_range(0, DEPTH - 1));
        int lasts = 0;
        run_transfer(b, 8'd32, 2, 1'b0, 9);
        total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL abort_timeout: got %b want 0", timed_out); end
        total++; if (got_d.size() !== 5) begin bad++; $display("[TB] FAIL abort_count: got %0d want 5", got_d.size()); end
        for (int i = 0; i < got_d.size(); i++) begin
            if (got_l[i]) lasts++;
            total++; if (got_d[i] !== exp_word(b, i)) begin bad++; $display("[TB] FAIL abort_word%0d: got %h want %h", i, got_d[i], exp_word(b, i)); end
        end
        total++; if (rv[9] !== 1'b1 || rv[10] !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid_drop: got %b%b want 10", rv[9], rv[10]); end
        total++; if (done_k !== 10 || done_cnt !== 1) begin bad++; $display("[TB] FAIL abort_done: got cycle %0d pulses %0d want 10/1", done_k, done_cnt); end
        for (int k = 1; k <= ncyc; k++) if (rv[k] && rl[k]) lasts++;
        total++; if (lasts !== 0) begin bad++; $display("[TB] FAIL abort_no_last: got %0d want 0", lasts); end
        run_transfer(7'h05, 8'd4, 0, 1'b0, -1);
        total++; if (got_d.size() !== 4 || done_cnt !== 1) begin bad++; $display("[TB] FAIL abort_next_count: got %0d/%0d want 4/1", got_d.size(), done_cnt); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            total++; if (got_d[i] !== exp_word(7'h05, i) || got_l[i] !== (i == 3)) begin bad++; $display("[TB] FAIL abort_next_word%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_word(7'h05, i), (i == 3)); end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion want summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; bus.m_ready = 1'b0;
`ifdef FTL_BRAM_READER_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_basic_stream();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_len_one();
        test_start_while_busy();
        test_full_buffer();
        test_reset_mid();
`ifdef FTL_BRAM_READER_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
